simon_key_sched: RTL and testbench

- Sequential SIMON key-expansion engine for the generalised SIMON 2N/MN family.
- Loads an M-word master key and streams round keys k[0]..k[T-1], one per valid/ready transfer, to the round datapath.
- Generalises the fixed 32-bit, 4-word combinational key step: parametrised word width, key-word count and z-sequence, with on-the-fly generation and backpressure.

---
 rtl/simon_key_sched.sv | 165 ++++++++++++++++
 tb/tb_simon_key_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/simon_key_sched.sv
// Sequential SIMON key expansion: loads an M-word master key and streams T round keys over valid/ready.
// Optional KS_REPLAY_EN keeps every emitted key and can replay the schedule in reverse via rev_start.
//
// state | meaning
// IDLE  | waiting for start (or rev_start with a valid store)
// RUN   | presenting round keys, advancing on each transfer
// FIN   | one-cycle done pulse, then back to IDLE
module simon_key_sched #(
  parameter int N     = 32,
  parameter int M     = 4,
  parameter int T     = 44,
  parameter int Z_IDX = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
`ifdef KS_REPLAY_EN
  input  logic           rev_start,
`endif
  input  logic [N*M-1:0] key_in,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic [N-1:0]   rk_data,
  output logic [7:0]     rk_idx,
  output logic           rk_last,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  // Standard SIMON z sequences, leftmost bit is consumed first.
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
  localparam logic [61:0] Z_SEQ = (Z_IDX == 0) ? Z0 : (Z_IDX == 1) ? Z1 :
                                  (Z_IDX == 2) ? Z2 : (Z_IDX == 3) ? Z3 : Z4;

  state_t       r_state;
  logic [N-1:0] r_win [M];
  logic [7:0]   r_idx;
  logic [5:0]   r_zc;
  logic         r_valid;
  logic         r_last;
  logic         r_busy;
  logic         r_done;

  logic         w_xfer;
  logic         w_rev;
  logic [N-1:0] w_rev_key;
  logic [N-1:0] w_tmp0;
  logic [N-1:0] w_tmp;
  logic [N-1:0] w_new;
  logic [5:0]   w_zpos;

  assign w_xfer = r_valid & rk_ready;

`ifdef KS_REPLAY_EN
  localparam int IW = $clog2(T);
  logic [N-1:0] r_store [T];
  logic         r_rev;
  logic         r_store_vld;

  // Store has no reset; r_store_vld guards its contents instead.
  always_ff @(posedge clk) begin
    if (w_xfer && !r_rev) r_store[r_idx[IW-1:0]] <= r_win[0];
  end

  assign w_rev     = r_rev;
  assign w_rev_key = r_store[IW'(r_idx - 8'd1)];
`else
  assign w_rev     = 1'b0;
  assign w_rev_key = '0;
`endif

  always_comb begin
    w_tmp0 = {r_win[M-1][2:0], r_win[M-1][N-1:3]};
    if (M == 4) w_tmp0 = w_tmp0 ^ r_win[1];
    w_tmp  = w_tmp0 ^ {w_tmp0[0], w_tmp0[N-1:1]};
    w_zpos = 6'd61 - r_zc;
    w_new  = ~r_win[0] ^ w_tmp ^ N'(3) ^ N'(Z_SEQ[w_zpos]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      for (int j = 0; j < M; j++) r_win[j] <= '0;
      r_idx   <= '0;
      r_zc    <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef KS_REPLAY_EN
      r_rev       <= 1'b0;
      r_store_vld <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            for (int j = 0; j < M; j++) r_win[j] <= key_in[N*j +: N];
            r_idx   <= '0;
            r_zc    <= '0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
`ifdef KS_REPLAY_EN
            r_rev   <= 1'b0;
          end else if (rev_start && r_store_vld) begin
            r_win[0] <= r_store[IW'(T-1)];
            r_idx    <= 8'(T-1);
            r_rev    <= 1'b1;
            r_valid  <= 1'b1;
            r_last   <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FIN;
`ifdef KS_REPLAY_EN
              r_store_vld <= 1'b1;
`endif
            end else if (w_rev) begin
              r_win[0] <= w_rev_key;
              r_idx    <= r_idx - 8'd1;
              r_last   <= (r_idx == 8'd1);
            end else begin
              for (int j = 0; j < M-1; j++) r_win[j] <= r_win[j+1];
              r_win[M-1] <= w_new;
              r_idx      <= r_idx + 8'd1;
              r_zc       <= (r_zc == 6'd61) ? 6'd0 : r_zc + 6'd1;
              r_last     <= (r_idx == 8'(T-2));
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rk_valid = r_valid;
  assign rk_data  = r_win[0];
  assign rk_idx   = r_idx;
  assign rk_last  = r_last;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_simon_key_sched.sv
// Directed bench for simon_key_sched: three parameter sets, backpressure, mid-run start/reset, optional replay.
module tb_simon_key_sched;

  logic clk = 1'b0;
  logic rst_n;
  logic st  [3];
  logic rdy [3];
`ifdef KS_REPLAY_EN
  logic rev_a;
`endif
  logic [127:0] key_a, key_c;
  logic [63:0]  key_b;

  logic v_a, v_b, v_c, l_a, l_b, l_c, b_a, b_b, b_c, d_a, d_b, d_c;
  logic [31:0] dat_a;
  logic [15:0] dat_b;
  logic [63:0] dat_c;
  logic [7:0]  i_a, i_b, i_c;

  logic        vld [3];
  logic        lst [3];
  logic        bsy [3];
  logic        dn  [3];
  logic [63:0] dat [3];
  logic [7:0]  idx [3];

  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] exp_k [256];
  logic [63:0] hand  [5];
  string       zs    [5];

  always #5 clk = ~clk;

  simon_key_sched #(.N(32), .M(4), .T(44), .Z_IDX(3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st[0]),
`ifdef KS_REPLAY_EN
    .rev_start(rev_a),
`endif
    .key_in(key_a), .rk_valid(v_a), .rk_ready(rdy[0]), .rk_data(dat_a),
    .rk_idx(i_a), .rk_last(l_a), .busy(b_a), .done(d_a));

  simon_key_sched #(.N(16), .M(4), .T(32), .Z_IDX(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st[1]),
`ifdef KS_REPLAY_EN
    .rev_start(1'b0),
`endif
    .key_in(key_b), .rk_valid(v_b), .rk_ready(rdy[1]), .rk_data(dat_b),
    .rk_idx(i_b), .rk_last(l_b), .busy(b_b), .done(d_b));

  simon_key_sched #(.N(64), .M(2), .T(68), .Z_IDX(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(st[2]),
`ifdef KS_REPLAY_EN
    .rev_start(1'b0),
`endif
    .key_in(key_c), .rk_valid(v_c), .rk_ready(rdy[2]), .rk_data(dat_c),
    .rk_idx(i_c), .rk_last(l_c), .busy(b_c), .done(d_c));

  assign vld[0] = v_a;  assign vld[1] = v_b;  assign vld[2] = v_c;
  assign lst[0] = l_a;  assign lst[1] = l_b;  assign lst[2] = l_c;
  assign bsy[0] = b_a;  assign bsy[1] = b_b;  assign bsy[2] = b_c;
  assign dn[0]  = d_a;  assign dn[1]  = d_b;  assign dn[2]  = d_c;
  assign idx[0] = i_a;  assign idx[1] = i_b;  assign idx[2] = i_c;
  assign dat[0] = {32'd0, dat_a};
  assign dat[1] = {48'd0, dat_b};
  assign dat[2] = dat_c;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, want, $time);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input int n,
                                       input logic [63:0] msk);
    return ((x >> r) | (x << (n - r))) & msk;
  endfunction

  // Reference schedule built as a flat array recurrence k[i+m] = f(k[i..i+m-1]).
  task automatic model(input int n, input int m, input int t, input int zi, input logic [255:0] key);
    logic [63:0] msk, tmp, zb;
    msk = (n == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << n) - 64'd1);
    for (int j = 0; j < m; j++) exp_k[j] = 64'(key >> (n * j)) & msk;
    for (int i = 0; i + m < t; i++) begin
      tmp = rotr(exp_k[i+m-1], 3, n, msk);
      if (m == 4) tmp = tmp ^ exp_k[i+1];
      tmp = tmp ^ rotr(tmp, 1, n, msk);
      zb  = (zs[zi][i % 62] == "1") ? 64'd1 : 64'd0;
      exp_k[i+m] = (~exp_k[i] ^ tmp ^ 64'd3 ^ zb) & msk;
    end
  endtask

  task automatic run(input int s, input int n, input int m, input int t, input int zi,
                     input logic [255:0] key, input bit rnd, input int start_at, input int rst_at);
    int   cnt = 0;
    int   budget = 0;
    bit   xfer;
    bit   held = 1'b0;
    logic [63:0] prev_d = '0;
    logic [7:0]  prev_i = '0;
    model(n, m, t, zi, key);
    st[s] = 1'b1;
    @(negedge clk);
    st[s] = 1'b0;
    chk("busy_run", bsy[s], 1);
    while (cnt < t && budget < 2000) begin
      budget++;
      chk("valid", vld[s], 1);
      if (!vld[s]) break;
      if (held) begin
        chk("hold_data", dat[s], prev_d);
        chk("hold_idx", idx[s], prev_i);
      end
      chk("key", dat[s], exp_k[cnt]);
      chk("idx", idx[s], cnt);
      chk("last", lst[s], cnt == t - 1);
      if (s == 0 && cnt < 5) chk("hand_key", dat[s], hand[cnt]);
      rdy[s] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cnt == start_at) st[s] = 1'b1;
      if (cnt == rst_at) rst_n = 1'b0;
      xfer   = rdy[s];
      held   = !xfer;
      prev_d = dat[s];
      prev_i = idx[s];
      @(negedge clk);
      st[s] = 1'b0;
      if (!rst_n) begin
        chk("rst_valid", vld[s], 0);
        chk("rst_data", dat[s], 0);
        chk("rst_idx", idx[s], 0);
        chk("rst_last", lst[s], 0);
        chk("rst_busy", bsy[s], 0);
        chk("rst_done", dn[s], 0);
        rst_n  = 1'b1;
        rdy[s] = 1'b1;
        return;
      end
      if (xfer) cnt++;
    end
    rdy[s] = 1'b1;
    if (cnt != t) begin
      chk("stream_len", cnt, t);
    end else begin
      chk("done_pulse", dn[s], 1);
      chk("fin_busy", bsy[s], 0);
      chk("fin_valid", vld[s], 0);
      st[s] = 1'b1;
      @(negedge clk);
      st[s] = 1'b0;
      chk("done_clear", dn[s], 0);
      chk("start_at_done", vld[s], 0);
      chk("idle_busy", bsy[s], 0);
    end
  endtask

`ifdef KS_REPLAY_EN
  task automatic run_rev();
    int cnt = 0;
    rev_a = 1'b1;
    @(negedge clk);
    rev_a = 1'b0;
    while (cnt < 44) begin
      chk("rev_valid", vld[0], 1);
      if (!vld[0]) break;
      chk("rev_key", dat[0], exp_k[43 - cnt]);
      chk("rev_idx", idx[0], 43 - cnt);
      chk("rev_last", lst[0], cnt == 43);
      @(negedge clk);
      cnt++;
    end
    if (cnt != 44) chk("rev_len", cnt, 44);
    else chk("rev_done", dn[0], 1);
    @(negedge clk);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    zs[0] = "11111010001001010110000111001101111101000100101011000011100110";
    zs[1] = "10001110111110010011000010110101000111011111001001100001011010";
    zs[2] = "10101111011100000011010010011000101000010001111110010110110011";
    zs[3] = "11011011101011000110010111100000010010001010011100110100001111";
    zs[4] = "11010001111001101011011000100000010111000011001010010011101111";
    hand[0] = 64'h03020100; hand[1] = 64'h0b0a0908; hand[2] = 64'h13121110;
    hand[3] = 64'h1b1a1918; hand[4] = 64'h70a011c3;
    key_a = 128'h1b1a1918_13121110_0b0a0908_03020100;
    key_b = 64'h1918_1110_0908_0100;
    key_c = 128'h0f0e0d0c0b0a0908_0706050403020100;
    for (int j = 0; j < 3; j++) begin
      st[j]  = 1'b0;
      rdy[j] = 1'b1;
    end
`ifdef KS_REPLAY_EN
    rev_a = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_valid", vld[0], 0);
    chk("reset_data", dat[0], 0);
    chk("reset_idx", idx[0], 0);
    chk("reset_last", lst[0], 0);
    chk("reset_busy", bsy[0], 0);
    chk("reset_done", dn[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef KS_REPLAY_EN
    rev_a = 1'b1;
    @(negedge clk);
    rev_a = 1'b0;
    chk("rev_while_invalid", vld[0], 0);
    @(negedge clk);
`endif
    run(0, 32, 4, 44, 3, 256'(key_a), 1'b0, -1, -1);
`ifdef KS_REPLAY_EN
    run_rev();
`endif
    run(0, 32, 4, 44, 3, 256'(key_a), 1'b1, -1, -1);
    run(0, 32, 4, 44, 3, 256'(key_a), 1'b0, 10, -1);
    run(0, 32, 4, 44, 3, 256'(key_a), 1'b0, -1, 20);
    @(negedge clk);
    run(0, 32, 4, 44, 3, 256'(key_a), 1'b1, -1, -1);
    run(1, 16, 4, 32, 0, 256'(key_b), 1'b0, -1, -1);
    run(2, 64, 2, 68, 2, 256'(key_c), 1'b1, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
